// File: rtl/demorgan_sweep_checker.sv
// ---------------------------------------------------------------------------
// demorgan_sweep_checker
//
// On-board self-test sequencer for a combinational 3-input De Morgan cell
// d = (~a | ~b) & ~c.
//
// The checker walks the cell through all eight input vectors. It holds each
// vector for SETTLE_CYCLES cycles, then samples the cell output on dut_d and
// compares it with an internal golden model. The results are:
//   - a saturating mismatch count,
//   - the first failing vector,
//   - a pass flag, valid whenever done is high.
//
// Optional build macro:
//   DEMORGAN_CHK_STOP_ON_ERR_EN - the first mismatch ends the sweep. The
//   failing vector stays on the stim outputs.
//
// Reset is synchronous and active-high (rst). It clears every result, even
// in the middle of a sweep.
// ---------------------------------------------------------------------------
module demorgan_sweep_checker #(
  parameter int SETTLE_CYCLES = 1,  // cycles each vector is held before sampling (>= 1)
  parameter int ERR_W         = 4   // width of the saturating mismatch counter
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             start,
  output logic             stim_a,
  output logic             stim_b,
  output logic             stim_c,
  input  logic             dut_d,
  output logic             busy,
  output logic             done,
  output logic             pass,
  output logic [ERR_W-1:0] err_count,
  output logic             first_err_vld,
  output logic [2:0]       first_err_vec
);

  // The settle counter only has to reach SETTLE_CYCLES-1.
  localparam int               CNT_W    = (SETTLE_CYCLES > 1) ? $clog2(SETTLE_CYCLES) : 1;
  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(SETTLE_CYCLES - 1);
  localparam logic [ERR_W-1:0] ERR_MAX  = '1;
  localparam logic [2:0]       VEC_LAST = 3'd7;

  typedef enum logic [1:0] {
    S_IDLE   = 2'd0,
    S_SETTLE = 2'd1,
    S_SAMPLE = 2'd2,
    S_DONE   = 2'd3
  } state_t;

  state_t           state_q,         state_d;
  logic [2:0]       vec_q,           vec_d;
  logic [CNT_W-1:0] cnt_q,           cnt_d;
  logic [ERR_W-1:0] err_count_q,     err_count_d;
  logic             first_err_vld_q, first_err_vld_d;
  logic [2:0]       first_err_vec_q, first_err_vec_d;

  logic exp_d;     // golden cell output for the current vector
  logic mismatch;  // cell disagrees with the golden model

  // Golden De Morgan model, evaluated on the registered vector.
  always_comb begin
    exp_d    = (~vec_q[2] | ~vec_q[1]) & ~vec_q[0];
    mismatch = dut_d ^ exp_d;
  end

  // Next-state and next-result logic for the sweep sequencer.
  always_comb begin
    // NOTE: every signal gets a hold-value default before the case statement.
    // Without it, any path that skips an assignment would infer a latch.
    state_d         = state_q;
    vec_d           = vec_q;
    cnt_d           = cnt_q;
    err_count_d     = err_count_q;
    first_err_vld_d = first_err_vld_q;
    first_err_vec_d = first_err_vec_q;

    unique case (state_q)
      // start is only honoured here, so a start while busy is ignored.
      S_IDLE, S_DONE: begin
        if (start) begin
          state_d         = S_SETTLE;
          vec_d           = '0;
          cnt_d           = '0;
          err_count_d     = '0;
          first_err_vld_d = 1'b0;
          first_err_vec_d = '0;
        end
      end

      S_SETTLE: begin
        cnt_d = cnt_q + 1'b1;
        if (cnt_q == CNT_LAST) begin
          state_d = S_SAMPLE;
        end
      end

      S_SAMPLE: begin
        if (mismatch) begin
          if (err_count_q != ERR_MAX) begin
            err_count_d = err_count_q + 1'b1;
          end
          if (!first_err_vld_q) begin
            first_err_vld_d = 1'b1;
            first_err_vec_d = vec_q;
          end
        end

        // vec holds at 7 after the last sample, so the stim outputs
        // keep showing the final vector while DONE.
        if (vec_q == VEC_LAST) begin
          state_d = S_DONE;
        end else begin
          state_d = S_SETTLE;
          vec_d   = vec_q + 3'd1;
          cnt_d   = '0;
        end

`ifdef DEMORGAN_CHK_STOP_ON_ERR_EN
        // Stop at the first failure. The failing vector stays on stim_*.
        if (mismatch) begin
          state_d = S_DONE;
          vec_d   = vec_q;
          cnt_d   = cnt_q;
        end
`endif
      end

      default: state_d = S_IDLE;
    endcase
  end

  // State and result registers, with synchronous reset.
  always_ff @(posedge clk) begin
    // NOTE: registers use non-blocking assignments, so every flop samples
    // pre-edge values. The combinational block above uses blocking
    // assignments instead.
    if (rst) begin
      state_q         <= S_IDLE;
      vec_q           <= '0;
      cnt_q           <= '0;
      err_count_q     <= '0;
      first_err_vld_q <= 1'b0;
      first_err_vec_q <= '0;
    end else begin
      state_q         <= state_d;
      vec_q           <= vec_d;
      cnt_q           <= cnt_d;
      err_count_q     <= err_count_d;
      first_err_vld_q <= first_err_vld_d;
      first_err_vec_q <= first_err_vec_d;
    end
  end

  // Outputs come straight from registers, so the stim lines are glitch-free.
  // pass is qualified by the registered done.
  always_comb begin
    stim_a        = vec_q[2];
    stim_b        = vec_q[1];
    stim_c        = vec_q[0];
    busy          = (state_q == S_SETTLE) || (state_q == S_SAMPLE);
    done          = (state_q == S_DONE);
    pass          = done && (err_count_q == '0);
    err_count     = err_count_q;
    first_err_vld = first_err_vld_q;
    first_err_vec = first_err_vec_q;
  end

endmodule

// File: tb/tb_demorgan_sweep_checker.sv
// ---------------------------------------------------------------------------
// tb_demorgan_sweep_checker
//
// Scoreboard bench for demorgan_sweep_checker.
//
// The cell under check is modelled as an 8-entry truth table (lut) indexed
// by {a,b,c}. Truth tables are either fixed fault cases or random.
//
// For every start that a checker accepts, the expected sweep result is
// pushed into a per-instance queue. The queue entry is computed from the
// truth table by a loop over the eight vectors.
//
// A monitor per instance pops an entry and compares it whenever done rises.
//
// Two instances run side by side:
//   - u_dut uses the default parameters.
//   - u_sat uses a narrow counter and a longer settle time.
// ---------------------------------------------------------------------------
module tb_demorgan_sweep_checker;

  localparam int S1 = 1, E1 = 4;  // default instance
  localparam int S2 = 3, E2 = 2;  // saturation / long-settle instance

  logic clk = 1'b0;
  logic rst = 1'b1;
  logic start = 1'b0;
  logic [7:0] lut = 8'h15;

  logic          stim_a, stim_b, stim_c, dut_d, busy, done, pass, fvld;
  logic [E1-1:0] err_count;
  logic [2:0]    fvec;

  logic          stim_a_s, stim_b_s, stim_c_s, dut_d_s, busy_s, done_s, pass_s, fvld_s;
  logic [E2-1:0] err_count_s;
  logic [2:0]    fvec_s;

  // Behavioural cell: each instance looks up its own stim vector in lut.
  assign dut_d   = lut[{stim_a, stim_b, stim_c}];
  assign dut_d_s = lut[{stim_a_s, stim_b_s, stim_c_s}];

  demorgan_sweep_checker #(.SETTLE_CYCLES(S1), .ERR_W(E1)) u_dut (
    .clk(clk), .rst(rst), .start(start),
    .stim_a(stim_a), .stim_b(stim_b), .stim_c(stim_c), .dut_d(dut_d),
    .busy(busy), .done(done), .pass(pass), .err_count(err_count),
    .first_err_vld(fvld), .first_err_vec(fvec)
  );

  demorgan_sweep_checker #(.SETTLE_CYCLES(S2), .ERR_W(E2)) u_sat (
    .clk(clk), .rst(rst), .start(start),
    .stim_a(stim_a_s), .stim_b(stim_b_s), .stim_c(stim_c_s), .dut_d(dut_d_s),
    .busy(busy_s), .done(done_s), .pass(pass_s), .err_count(err_count_s),
    .first_err_vld(fvld_s), .first_err_vec(fvec_s)
  );

  always #5 clk = ~clk;

  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  int checks = 0;
  int errors = 0;

  typedef struct {
    int exp_cyc;  // cycle count at which done must first be seen
    int lat;
    int err;
    int vld;
    int fvec;
    int pass;
    int last;     // final vector on stim after the sweep
  } exp_t;

  exp_t sb_q[$];
  exp_t sb_s[$];
  int   obs_q[$];
  int   obs_s[$];

  task automatic check(input string name, input int act, input int req);
    checks++;
    if (act !== req) begin
      errors++;
      $display("FAIL %s: actual %0d required %0d (t=%0t)", name, act, req, $time);
    end
  endtask

  // Reference: evaluate every vector against the De Morgan rule and
  // accumulate the result the checker should report.
  function automatic exp_t model(input logic [7:0] t, input int settle, input int errmax);
    exp_t r;
    bit   stopped;
    r.exp_cyc = 0;
    r.err     = 0;
    r.vld     = 0;
    r.fvec    = 0;
    r.last    = 7;
    r.lat     = 8 * (settle + 1);
    stopped   = 1'b0;
    for (int v = 0; v < 8 && !stopped; v++) begin
      int a, b, c, g;
      a = (v / 4) % 2;
      b = (v / 2) % 2;
      c = v % 2;
      g = (((a == 0) || (b == 0)) && (c == 0)) ? 1 : 0;
      if (int'(t[v]) != g) begin
        if (r.err < errmax) r.err++;
        if (r.vld == 0) begin
          r.vld  = 1;
          r.fvec = v;
        end
`ifdef DEMORGAN_CHK_STOP_ON_ERR_EN
        stopped = 1'b1;
        r.last  = v;
        r.lat   = (v + 1) * (settle + 1);
`endif
      end
    end
    r.pass = (r.err == 0) ? 1 : 0;
    return r;
  endfunction

  // True when the observed vectors were exactly 0, 1, ..., last in order.
  function automatic int walk_ok(input int q[$], input int last);
    if (q.size() != last + 1) return 0;
    foreach (q[i]) if (q[i] != i) return 0;
    return 1;
  endfunction

  // Monitor for the default instance.
  exp_t mon_e;
  bit   dprev = 1'b0;
  always @(negedge clk) begin
    if (!rst) begin
      if (busy && (obs_q.size() == 0 || obs_q[$] != int'({stim_a, stim_b, stim_c})))
        obs_q.push_back(int'({stim_a, stim_b, stim_c}));
      if (done && !dprev) begin
        if (sb_q.size() == 0) begin
          checks++;
          errors++;
          $display("FAIL main_unexpected_done: actual done=1 required no done (t=%0t)", $time);
        end else begin
          mon_e = sb_q.pop_front();
          check("main_latency",   cyc,                              mon_e.exp_cyc);
          check("main_err_count", int'(err_count),                  mon_e.err);
          check("main_first_vld", int'(fvld),                       mon_e.vld);
          check("main_first_vec", int'(fvec),                       mon_e.fvec);
          check("main_pass",      int'(pass),                       mon_e.pass);
          check("main_busy_done", int'(busy),                       0);
          check("main_stim_hold", int'({stim_a, stim_b, stim_c}),   mon_e.last);
          check("main_stim_walk", walk_ok(obs_q, mon_e.last),       1);
        end
        obs_q.delete();
      end
    end
    dprev = done;
  end

  // Monitor for the saturating instance.
  exp_t mon_s;
  bit   dprev_s = 1'b0;
  always @(negedge clk) begin
    if (!rst) begin
      if (busy_s && (obs_s.size() == 0 || obs_s[$] != int'({stim_a_s, stim_b_s, stim_c_s})))
        obs_s.push_back(int'({stim_a_s, stim_b_s, stim_c_s}));
      if (done_s && !dprev_s) begin
        if (sb_s.size() == 0) begin
          checks++;
          errors++;
          $display("FAIL sat_unexpected_done: actual done=1 required no done (t=%0t)", $time);
        end else begin
          mon_s = sb_s.pop_front();
          check("sat_latency",    cyc,                                  mon_s.exp_cyc);
          check("sat_err_count",  int'(err_count_s),                    mon_s.err);
          check("sat_first_vld",  int'(fvld_s),                         mon_s.vld);
          check("sat_first_vec",  int'(fvec_s),                         mon_s.fvec);
          check("sat_pass",       int'(pass_s),                         mon_s.pass);
          check("sat_stim_hold",  int'({stim_a_s, stim_b_s, stim_c_s}), mon_s.last);
          check("sat_stim_walk",  walk_ok(obs_s, mon_s.last),           1);
        end
        obs_s.delete();
      end
    end
    dprev_s = done_s;
  end

  // Pulse start for one edge. Expectations are pushed only for instances
  // that were not busy at that edge, since a busy checker ignores start.
  task automatic do_start();
    bit   idle1, idle2;
    exp_t e;
    @(negedge clk);
    idle1 = !busy;
    idle2 = !busy_s;
    start = 1'b1;
    @(posedge clk);
    #1;
    start = 1'b0;
    if (idle1) begin
      e = model(lut, S1, (1 << E1) - 1);
      e.exp_cyc = cyc + e.lat;
      sb_q.push_back(e);
    end
    if (idle2) begin
      e = model(lut, S2, (1 << E2) - 1);
      e.exp_cyc = cyc + e.lat;
      sb_s.push_back(e);
    end
  endtask

  // Wait, with a cycle budget, until both checkers have left the sweep.
  task automatic wait_idle();
    int n;
    n = 0;
    do begin
      @(negedge clk);
      n++;
    end while ((busy || busy_s) && n < 500);
    if (busy || busy_s) begin
      checks++;
      errors++;
      $display("FAIL sweep_timeout: actual busy after %0d cycles required idle", n);
    end
  endtask

  task automatic run(input logic [7:0] t);
    lut = t;
    do_start();
    wait_idle();
  endtask

  task automatic check_cleared(input string tag);
    check({tag, "_busy"},      int'(busy),                          0);
    check({tag, "_done"},      int'(done),                          0);
    check({tag, "_pass"},      int'(pass),                          0);
    check({tag, "_err_count"}, int'(err_count),                     0);
    check({tag, "_first_vld"}, int'(fvld),                          0);
    check({tag, "_first_vec"}, int'(fvec),                          0);
    check({tag, "_stim"},      int'({stim_a, stim_b, stim_c}),      0);
    check({tag, "_sat_all"},   int'({busy_s, done_s, pass_s, err_count_s,
                                     fvld_s, fvec_s, stim_a_s, stim_b_s, stim_c_s}), 0);
  endtask

  initial begin
    // Power-on reset.
    repeat (3) @(posedge clk);
    @(negedge clk);
    check_cleared("reset");
    rst = 1'b0;

    // Fixed cases: good cell, stuck-at-0, stuck-at-1, cell wired as ~(a|b)&~c.
    run(8'h15);
    run(8'h00);
    run(8'hFF);
    run(8'h01);

    // A start pulse in mid-sweep must not restart either checker.
    lut = 8'h01;
    do_start();
    repeat (5) @(negedge clk);
    do_start();
    wait_idle();

    // Reset at cycle 7 of a sweep.
    lut = 8'h15;
    do_start();
    repeat (6) @(posedge clk);
    @(negedge clk);
    rst = 1'b1;
    @(posedge clk);
    #1;
    sb_q.delete();
    sb_s.delete();
    obs_q.delete();
    obs_s.delete();
    @(negedge clk);
    check_cleared("midrst");
    rst = 1'b0;

    // A new start after the reset must give a clean full sweep.
    run(8'h15);

    // Random cell truth tables.
    repeat (12) run(8'($urandom));

    repeat (2) @(negedge clk);
    check("scoreboard_drained", sb_q.size() + sb_s.size(), 0);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
